out_fifo: RTL and testbench
===========================

OUT_FIFO -- requirements
Module: out_fifo

Interface
REQ-001 The block SHALL have parameters DATA_SIZE_BIT (default 2, log2 of word width), DATA_WIDTH (default 2**DATA_SIZE_BIT, bits per word), FIFO_SIZE_BIT (default 7, log2 of depth), FIFO_WIDTH (default 2**FIFO_SIZE_BIT, depth in words), ALMOST_EMPTY_OFFSET (default FIFO_WIDTH/4) and ALMOST_FULL_OFFSET (default 3*FIFO_WIDTH/4).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: inClock  in  1  clock; inReset  in  1  asynchronous active-low reset.
REQ-003 The block SHALL have the following ports:
- inBitValid  in  1  serial-side strobe; only its rising edge is acted on
- inBit  in  1  serial data bit, stable while inBitValid is high
- inReadEnable  in  1  word-read request; only its rising edge is acted on
- outData  out  DATA_WIDTH  last word read
- outDataValid  out  1  one-cycle pulse, outData is fresh
- outBitDone  out  1  one-cycle pulse acknowledging a captured bit
- outCount  out  FIFO_SIZE_BIT+1  stored word count
- outFull / outEmpty / outAlmostFull / outAlmostEmpty  out  1 each  level flags
- outWriteError / outReadError  out  1 each  sticky error flags

Function
REQ-004 Each of inBitValid and inReadEnable SHALL feed a previous-value register; a rise is input==1 with previous==0 at a clock edge. A level held high SHALL produce exactly one event.
REQ-005 On an inBitValid rise, inBit SHALL be stored at position k of the assembly register, and k SHALL advance. k is a DATA_SIZE_BIT-bit index that wraps from DATA_WIDTH-1 to 0. Bits are assembled LSB first.
REQ-006 outBitDone SHALL be high for exactly the cycle after each bit capture.
REQ-007 On the capture with k==DATA_WIDTH-1, the completed word {inBit, assembly[DATA_WIDTH-2:0]} SHALL be written to mem[wr_ptr] at that same edge, provided outCount<FIFO_WIDTH before the edge; wr_ptr and outCount then increment.
REQ-008 If outCount==FIFO_WIDTH at a word-completion edge, the word SHALL be dropped, wr_ptr and outCount SHALL be unchanged, and outWriteError SHALL be set. k still wraps to 0. A read in the same cycle does not rescue the word.
REQ-009 The read FSM SHALL have states IDLE, RCHECK, RREAD, RDONE and RERROR, with these transitions:
- IDLE->RCHECK on an inReadEnable rise
- RCHECK->RERROR if outCount==0, else RCHECK->RREAD
- RREAD->RDONE
- RDONE->IDLE and RERROR->IDLE unconditionally
- illegal encodings->IDLE
REQ-010 Read rises occurring outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-011 In RREAD, outData SHALL load mem[rd_ptr] at the exit edge, rd_ptr SHALL increment, and outCount SHALL decrement.
REQ-012 outDataValid SHALL be high exactly while in RDONE, which is the third cycle after the cycle in which the rise is sampled. outData SHALL otherwise hold its value.
REQ-013 A write commit and an RREAD in the same cycle SHALL leave outCount unchanged; both pointers advance.
REQ-014 wr_ptr and rd_ptr SHALL be FIFO_SIZE_BIT wide and wrap naturally from FIFO_WIDTH-1 to 0. outCount SHALL range 0..FIFO_WIDTH.
REQ-015 The flags SHALL be combinational from outCount:
- outFull = (outCount==FIFO_WIDTH)
- outEmpty = (outCount==0)
- outAlmostFull = (outCount>=ALMOST_FULL_OFFSET)
- outAlmostEmpty = (outCount<=ALMOST_EMPTY_OFFSET)
REQ-016 outReadError SHALL be set on entry to RERROR and cleared in RREAD. outWriteError SHALL be cleared by the next successful word commit. Both flags are sticky otherwise.
REQ-017 A failed read (RERROR) SHALL NOT assert outDataValid and SHALL NOT change outData, rd_ptr or outCount.

Reset
REQ-018 While inReset==0, the following SHALL be forced immediately, independent of inClock:
- state=IDLE; k=0; wr_ptr=rd_ptr=outCount=0
- assembly register=0; outData=0
- previous-value registers=0
- outDataValid=outBitDone=outWriteError=outReadError=0
REQ-019 Memory contents need not be reset. After reset, outEmpty=1, outAlmostEmpty=1, outFull=0 and outAlmostFull=0.
REQ-020 A reset applied mid-word SHALL discard the partial word. The next captured bit is bit 0 of a new word.

Verification
REQ-021 The bench SHALL cover: reset release -> outEmpty=1, outAlmostEmpty=1, outCount=0, all pulses and errors 0.
REQ-022 The bench SHALL cover: bits 1,0,1,1 as four separate inBitValid rises -> four outBitDone pulses, outCount=1; then one inReadEnable rise -> outDataValid high on the third cycle after the rise is sampled, outData=4'hD, outCount=0.
REQ-023 The bench SHALL cover: inReadEnable rise while empty -> outReadError=1, no outDataValid, outData unchanged; a later successful read clears outReadError.
REQ-024 The bench SHALL cover: 128 words written -> outFull=1, outAlmostFull=1; a 129th word -> outWriteError=1, outCount=128; one read then one write -> outWriteError=0, outCount=128, and the read returns word 0.
REQ-025 The bench SHALL cover: 300 words streamed with interleaved reads, including same-cycle commit and RREAD -> in-order data across pointer wrap, with outCount never exceeding 128.
REQ-026 The bench SHALL cover: two bits captured, reset pulsed, then 0,1,1,0 sent -> read returns 4'h6; inBitValid held high for 10 cycles -> exactly one bit captured.

Source files
------------

// File: rtl/out_fifo.sv
// out_fifo: serial-to-parallel word assembler feeding a FIFO, with an edge-triggered
// word-read handshake, level flags and sticky error flags.  Rev 1.0
`default_nettype none

module out_fifo #(
  parameter int DATA_SIZE_BIT       = 2,
  parameter int DATA_WIDTH          = 2**DATA_SIZE_BIT,
  parameter int FIFO_SIZE_BIT       = 7,
  parameter int FIFO_WIDTH          = 2**FIFO_SIZE_BIT,
  parameter int ALMOST_EMPTY_OFFSET = FIFO_WIDTH/4,
  parameter int ALMOST_FULL_OFFSET  = 3*FIFO_WIDTH/4
) (
  input  logic                     inClock,
  input  logic                     inReset,
  input  logic                     inBitValid,
  input  logic                     inBit,
  input  logic                     inReadEnable,
  output logic [DATA_WIDTH-1:0]    outData,
  output logic                     outDataValid,
  output logic                     outBitDone,
  output logic [FIFO_SIZE_BIT:0]   outCount,
  output logic                     outFull,
  output logic                     outEmpty,
  output logic                     outAlmostFull,
  output logic                     outAlmostEmpty,
  output logic                     outWriteError,
  output logic                     outReadError
);

  localparam logic [DATA_SIZE_BIT-1:0] K_LAST  = DATA_SIZE_BIT'(DATA_WIDTH - 1);
  localparam logic [DATA_SIZE_BIT-1:0] K_ONE   = DATA_SIZE_BIT'(1);
  localparam logic [FIFO_SIZE_BIT-1:0] PTR_ONE = FIFO_SIZE_BIT'(1);
  localparam logic [FIFO_SIZE_BIT:0]   CNT_ONE = (FIFO_SIZE_BIT+1)'(1);
  localparam logic [FIFO_SIZE_BIT:0]   CNT_FULL = (FIFO_SIZE_BIT+1)'(FIFO_WIDTH);
  localparam logic [FIFO_SIZE_BIT:0]   CNT_AF   = (FIFO_SIZE_BIT+1)'(ALMOST_FULL_OFFSET);
  localparam logic [FIFO_SIZE_BIT:0]   CNT_AE   = (FIFO_SIZE_BIT+1)'(ALMOST_EMPTY_OFFSET);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RCHECK = 3'd1,
    RREAD  = 3'd2,
    RDONE  = 3'd3,
    RERROR = 3'd4
  } rd_state_t;

  rd_state_t state, state_nxt;

  logic                     prev_valid;
  logic                     prev_read;
  logic [DATA_SIZE_BIT-1:0] k;
  logic [DATA_WIDTH-1:0]    assembly;
  logic [FIFO_SIZE_BIT-1:0] wr_ptr;
  logic [FIFO_SIZE_BIT-1:0] rd_ptr;
  logic [DATA_WIDTH-1:0]    mem [FIFO_WIDTH];

  logic                     bit_rise;
  logic                     read_rise;
  logic                     word_done;
  logic                     commit;
  logic                     drop;
  logic                     do_read;
  logic [DATA_WIDTH-1:0]    word;

  assign bit_rise  = inBitValid & ~prev_valid;
  assign read_rise = inReadEnable & ~prev_read;
  assign word_done = bit_rise && (k == K_LAST);
  assign commit    = word_done && (outCount != CNT_FULL);
  assign drop      = word_done && (outCount == CNT_FULL);
  assign do_read   = (state == RREAD);
  assign word      = {inBit, assembly[DATA_WIDTH-2:0]};

  assign outFull        = (outCount == CNT_FULL);
  assign outEmpty       = (outCount == '0);
  assign outAlmostFull  = (outCount >= CNT_AF);
  assign outAlmostEmpty = (outCount <= CNT_AE);
  assign outDataValid   = (state == RDONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (read_rise) state_nxt = RCHECK;
      RCHECK:  state_nxt = (outCount == '0) ? RERROR : RREAD;
      RREAD:   state_nxt = RDONE;
      RDONE:   state_nxt = IDLE;
      RERROR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      state      <= IDLE;
      prev_valid <= 1'b0;
      prev_read  <= 1'b0;
      k          <= '0;
      assembly   <= '0;
      outBitDone <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev_valid <= inBitValid;
      prev_read  <= inReadEnable;
      outBitDone <= bit_rise;
      if (bit_rise) begin
        assembly[k] <= inBit;
        k           <= k + K_ONE;
      end
    end
  end

  // Storage is deliberately left out of reset; occupancy is tracked by the pointers.
  always_ff @(posedge inClock) begin
    if (commit) mem[wr_ptr] <= word;
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outCount      <= '0;
      outData       <= '0;
      outWriteError <= 1'b0;
      outReadError  <= 1'b0;
    end else begin
      if (commit) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_read) begin
        outData <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      case ({commit, do_read})
        2'b10:   outCount <= outCount + CNT_ONE;
        2'b01:   outCount <= outCount - CNT_ONE;
        default: outCount <= outCount;
      endcase
      if (commit)    outWriteError <= 1'b0;
      else if (drop) outWriteError <= 1'b1;
      if (do_read)                                   outReadError <= 1'b0;
      else if (state == RCHECK && outCount == '0)    outReadError <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_out_fifo.sv
// Directed self-checking bench for out_fifo with a queue model of stored words.
`default_nettype none

module tb_out_fifo;

  logic       inClock = 1'b0;
  logic       inReset;
  logic       inBitValid;
  logic       inBit;
  logic       inReadEnable;
  logic [3:0] outData;
  logic       outDataValid;
  logic       outBitDone;
  logic [7:0] outCount;
  logic       outFull, outEmpty, outAlmostFull, outAlmostEmpty;
  logic       outWriteError, outReadError;

  int checks = 0;
  int errors = 0;
  logic [3:0] q[$];

  out_fifo dut (
    .inClock(inClock), .inReset(inReset), .inBitValid(inBitValid), .inBit(inBit),
    .inReadEnable(inReadEnable), .outData(outData), .outDataValid(outDataValid),
    .outBitDone(outBitDone), .outCount(outCount), .outFull(outFull), .outEmpty(outEmpty),
    .outAlmostFull(outAlmostFull), .outAlmostEmpty(outAlmostEmpty),
    .outWriteError(outWriteError), .outReadError(outReadError)
  );

  always #5 inClock = ~inClock;

  task automatic send_bit(input logic b);
    @(negedge inClock);
    inBit = b;
    inBitValid = 1'b1;
    @(negedge inClock);
    checks++;
    if (outBitDone !== 1'b1) begin
      errors++;
      $display("FAIL bit_done got %b want 1", outBitDone);
    end
    inBitValid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    bit push;
    push = (q.size() < 128);
    for (int i = 0; i < 4; i++) send_bit(w[i]);
    if (push) q.push_back(w);
    checks++;
    if (outCount !== 8'(q.size())) begin
      errors++;
      $display("FAIL write_count got %0d want %0d", outCount, q.size());
    end
    if (!push) begin
      checks++;
      if (outWriteError !== 1'b1) begin
        errors++;
        $display("FAIL write_error_set got %b want 1", outWriteError);
      end
    end
  endtask

  task automatic do_read(input logic exp_ok, output logic [3:0] d);
    d = 4'h0;
    @(negedge inClock);
    inReadEnable = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      @(negedge inClock);
      if (n == 1) inReadEnable = 1'b0;
      checks++;
      if (n < 3) begin
        if (outDataValid !== 1'b0) begin
          errors++;
          $display("FAIL early_valid cycle %0d got %b want 0", n, outDataValid);
        end
      end else begin
        d = outData;
        if (outDataValid !== exp_ok) begin
          errors++;
          $display("FAIL valid_cycle3 got %b want %b", outDataValid, exp_ok);
        end
      end
    end
    @(negedge inClock);
  endtask

  task automatic read_check();
    logic [3:0] e, d;
    e = q.pop_front();
    do_read(1'b1, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL read_data got %h want %h", d, e);
    end
    checks++;
    if (outCount !== 8'(q.size()) || outReadError !== 1'b0) begin
      errors++;
      $display("FAIL read_count got %0d/%b want %0d/0", outCount, outReadError, q.size());
    end
  endtask

  // Last bit of a word lands on the same edge that leaves RREAD.
  task automatic overlap_word(input logic [3:0] w);
    logic [3:0] e;
    logic [7:0] cnt0;
    for (int i = 0; i < 3; i++) send_bit(w[i]);
    e = q.pop_front();
    cnt0 = outCount;
    @(negedge inClock);
    inReadEnable = 1'b1;
    @(negedge inClock);
    inReadEnable = 1'b0;
    @(negedge inClock);
    inBit = w[3];
    inBitValid = 1'b1;
    @(negedge inClock);
    checks++;
    if (outDataValid !== 1'b1 || outData !== e || outCount !== cnt0 || outBitDone !== 1'b1) begin
      errors++;
      $display("FAIL overlap got v=%b d=%h c=%0d bd=%b want v=1 d=%h c=%0d bd=1",
               outDataValid, outData, outCount, outBitDone, e, cnt0);
    end
    inBitValid = 1'b0;
    q.push_back(w);
    @(negedge inClock);
  endtask

  task automatic test_reset();
    inReset = 1'b0;
    inBitValid = 1'b0;
    inBit = 1'b0;
    inReadEnable = 1'b0;
    repeat (2) @(negedge inClock);
    inReset = 1'b1;
    @(negedge inClock);
    checks++;
    if (outCount !== 8'd0 || outEmpty !== 1'b1 || outAlmostEmpty !== 1'b1 ||
        outFull !== 1'b0 || outAlmostFull !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got c=%0d e=%b ae=%b f=%b af=%b want 0 1 1 0 0",
               outCount, outEmpty, outAlmostEmpty, outFull, outAlmostFull);
    end
    checks++;
    if (outDataValid !== 1'b0 || outBitDone !== 1'b0 || outWriteError !== 1'b0 ||
        outReadError !== 1'b0 || outData !== 4'h0) begin
      errors++;
      $display("FAIL reset_pulses got dv=%b bd=%b we=%b re=%b d=%h want all 0",
               outDataValid, outBitDone, outWriteError, outReadError, outData);
    end
  endtask

  task automatic test_basic();
    logic [3:0] d;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    checks++;
    if (outCount !== 8'd1 || outEmpty !== 1'b0) begin
      errors++;
      $display("FAIL basic_count got %0d want 1", outCount);
    end
    do_read(1'b1, d);
    checks++;
    if (d !== 4'hD || outCount !== 8'd0) begin
      errors++;
      $display("FAIL basic_read got d=%h c=%0d want d=d c=0", d, outCount);
    end
  endtask

  task automatic test_read_empty();
    logic [3:0] d;
    do_read(1'b0, d);
    checks++;
    if (outReadError !== 1'b1 || outData !== 4'hD || outCount !== 8'd0) begin
      errors++;
      $display("FAIL empty_read got re=%b d=%h c=%0d want re=1 d=d c=0",
               outReadError, outData, outCount);
    end
    send_word(4'h9);
    read_check();
  endtask

  task automatic test_full();
    logic [3:0] d;
    for (int i = 0; i < 128; i++) begin
      send_word(4'((i * 7 + 3) & 15));
      if (q.size() == 32 || q.size() == 33) begin
        checks++;
        if (outAlmostEmpty !== (q.size() == 32)) begin
          errors++;
          $display("FAIL almost_empty at %0d got %b", q.size(), outAlmostEmpty);
        end
      end
      if (q.size() == 95 || q.size() == 96) begin
        checks++;
        if (outAlmostFull !== (q.size() == 96)) begin
          errors++;
          $display("FAIL almost_full at %0d got %b", q.size(), outAlmostFull);
        end
      end
    end
    checks++;
    if (outFull !== 1'b1 || outAlmostFull !== 1'b1 || outCount !== 8'd128) begin
      errors++;
      $display("FAIL full_flags got f=%b af=%b c=%0d want 1 1 128", outFull, outAlmostFull, outCount);
    end
    send_word(4'hE);
    d = q[0];
    checks++;
    if (d !== 4'h3) begin
      errors++;
      $display("FAIL model_head got %h want 3", d);
    end
    read_check();
    send_word(4'hA);
    checks++;
    if (outWriteError !== 1'b0 || outCount !== 8'd128) begin
      errors++;
      $display("FAIL write_error_clear got we=%b c=%0d want 0 128", outWriteError, outCount);
    end
    while (q.size() > 0) read_check();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 300; i++) begin
      if (q.size() > 0 && (i % 3) == 0) overlap_word(4'((i * 5 + 1) & 15));
      else send_word(4'((i * 5 + 1) & 15));
      checks++;
      if (outCount > 8'd128) begin
        errors++;
        $display("FAIL stream_bound got %0d want <=128", outCount);
      end
      if ((i % 2) == 1 && q.size() > 0) read_check();
    end
    while (q.size() > 0) read_check();
    checks++;
    if (outEmpty !== 1'b1) begin
      errors++;
      $display("FAIL stream_drain got empty=%b want 1", outEmpty);
    end
  endtask

  task automatic test_reset_mid();
    send_bit(1'b1);
    send_bit(1'b1);
    #2 inReset = 1'b0;
    #1;
    checks++;
    if (outBitDone !== 1'b0 || outCount !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got bd=%b c=%0d want 0 0", outBitDone, outCount);
    end
    #1 inReset = 1'b1;
    q.delete();
    send_word(4'h6);
    read_check();
    @(negedge inClock);
    inBit = 1'b1;
    inBitValid = 1'b1;
    begin
      int pulses = 0;
      for (int n = 0; n < 10; n++) begin
        @(negedge inClock);
        if (outBitDone === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1) begin
        errors++;
        $display("FAIL held_valid got %0d pulses want 1", pulses);
      end
    end
    inBitValid = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    q.push_back(4'h1);
    checks++;
    if (outCount !== 8'd1) begin
      errors++;
      $display("FAIL held_count got %0d want 1", outCount);
    end
    read_check();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_read_empty();
    test_full();
    test_stream();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
